// File: rtl/cardinal_nic.sv
// cardinal_nic: CPU memory-mapped port to Cardinal ring router, with single-entry input and output channel buffers.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            nicAddr,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic [0:DATA_WIDTH-1] nicDataIn,
    output logic [0:DATA_WIDTH-1] nicDataOut,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);
    logic [0:DATA_WIDTH-1] in_buf_q, in_buf_d, out_buf_q, out_buf_d;
    logic                  in_full_q, in_full_d, out_full_q, out_full_d;
    logic                  rd, wr, cap, pop, push;

    assign rd   = nicEn & ~nicWrEn;
    assign wr   = nicEn & nicWrEn;
    assign cap  = net_si & ~in_full_q;
    assign pop  = rd & (nicAddr == 2'b00) & in_full_q;
    assign push = wr & (nicAddr == 2'b10) & ~out_full_q;

    assign net_ri = ~in_full_q;
    assign net_do = out_buf_q;
    // bit 0 of the packet is its virtual channel; inject only on the matching ring polarity
    assign net_so = out_full_q & net_ro & (out_buf_q[0] == net_polarity);

    always_comb begin
        nicDataOut = !rd                 ? '0 :
                     nicAddr == 2'b00    ? in_buf_q :
                     nicAddr == 2'b01    ? {{(DATA_WIDTH-1){1'b0}}, in_full_q} :
                     nicAddr == 2'b10    ? out_buf_q :
                                           {{(DATA_WIDTH-1){1'b0}}, out_full_q};
        in_buf_d   = cap ? net_di : in_buf_q;
        in_full_d  = cap | (in_full_q & ~pop);
        out_buf_d  = push ? nicDataIn : out_buf_q;
        out_full_d = push | (out_full_q & ~net_so);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end
endmodule
